multiword_cla_seq: RTL and testbench
====================================

Name: multiword_cla_seq

Overview:
- Sequencer that performs wide add/subtract by time-multiplexing one 8-bit carry-lookahead adder slice over WORDS cycles.
- Each cycle it feeds one operand byte, least significant first. The slice carry-out is registered and returned as the next byte's carry-in.
- Sits between a register-file/ALU front end (start/done handshake) and the 8-bit CLA datapath. Gives N×8-bit arithmetic at the area of one slice.

Parameters:
- W, 8, slice width in bits; must match the CLA datapath.
- WORDS, 4, number of slices per operation; ≥2.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only when not busy
- sub  input  1  0 = A+B+cin, 1 = A−B (cin ignored)
- a_in  input  W*WORDS  operand A, captured on accepted start
- b_in  input  W*WORDS  operand B, captured on accepted start
- cin  input  1  carry-in for add, captured on accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse, result valid
- sum  output  W*WORDS  result; holds until next accepted start
- cout  output  1  final carry-out (for sub: 1 = no borrow)
- ovf  output  1  signed overflow of the full-width result

Behaviour:
- Interface: one clock; reset is synchronous and active-high. Clock port is clk, reset port is rst.
- States: IDLE, RUN, DONE (2-bit encoding).
- Reset, at the rising edge with rst=1:
  - state=IDLE
  - busy=0, done=0, sum=0, cout=0, ovf=0
  - internal idx=0, carry register=0
  - Applies in any state and aborts an operation in progress with no done pulse.
- Start acceptance: start is accepted at an edge when state is IDLE or DONE. On acceptance:
  - A and B are latched into shift registers. If sub=1, B is stored bit-inverted.
  - carry ← (sub ? 1 : cin); idx ← 0; sum ← 0.
  - state ← RUN.
- start is ignored while in RUN. It is not queued.
- RUN: on each edge, the slice computes the lowest W bits of A and B plus the carry register.
  - The W-bit result is written to sum word idx.
  - carry ← slice carry-out.
  - A and B shift right by W; idx increments.
- Slice equations: g=a&b, p=a^b, c[0]=carry, c[i+1]=g[i]|(p[i]&c[i]), s=p^c[0..W−1]. The carries are computed in lookahead form, with no ripple loop in RTL.
- At the edge where idx==WORDS−1:
  - state ← DONE.
  - cout ← carry-out of that slice.
  - ovf ← carry into the MSB XOR carry out of the MSB of that slice.
- Latency: start accepted at edge T0. Words are processed at edges T1..T(WORDS). done=1 for exactly the cycle after edge T(WORDS).
- busy=1 for the WORDS cycles between T0 and T(WORDS). It is 0 in IDLE and DONE.
- DONE lasts one cycle, then state ← IDLE unless start is accepted at that edge. Back-to-back: start held high gives one operation every WORDS+1 cycles.
- sum, cout and ovf are registered. They are valid from done and stable until the next accepted start, at which point sum clears to 0.
- Wrap-around: results are modulo 2^(W*WORDS). Overflow is reported only via cout/ovf.
- Operand inputs may change freely after the accepting edge.

Test Plan:
- WORDS=4, sub=0, cin=0, A=0x000000FF, B=0x00000001 → done 5 edges after start edge; sum=0x00000100, cout=0, ovf=0; busy high exactly 4 cycles.
- Full carry chain: A=0xFFFFFFFF, B=0x00000000, cin=1 → sum=0x00000000, cout=1, ovf=0.
- Subtract: sub=1, A=0x00000005, B=0x00000007, cin=1 → sum=0xFFFFFFFE, cout=0 (borrow), ovf=0. Then A=0x80000000, B=0x00000001 → sum=0x7FFFFFFF, cout=1, ovf=1.
- Signed add overflow: A=0x7FFFFFFF, B=0x00000001 → sum=0x80000000, ovf=1, cout=0.
- start pulsed during RUN with different operands → ignored; original result is delivered unchanged. start held high continuously → done pulses every 5 cycles, each with correct results.
- rst asserted at the 2nd RUN cycle → next cycle state=IDLE, busy=0, done never pulses, sum=0. A new start then completes normally.

Source files
------------

// File: rtl/multiword_cla_seq_if.sv
// Start/done handshake and operand/result bus between the ALU front end
// and the multiword CLA sequencer.
interface multiword_cla_seq_if #(
    parameter int W     = 8,
    parameter int WORDS = 4
);
    logic                 start;
    logic                 sub;
    logic [W*WORDS-1:0]   a_in;
    logic [W*WORDS-1:0]   b_in;
    logic                 cin;
    logic                 busy;
    logic                 done;
    logic [W*WORDS-1:0]   sum;
    logic                 cout;
    logic                 ovf;

    modport master (
        output start, sub, a_in, b_in, cin,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, a_in, b_in, cin,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/multiword_cla_seq.sv
// Wide add/subtract built from one W-bit carry-lookahead slice reused
// over WORDS cycles, least significant word first.
module multiword_cla_seq #(
    parameter int W     = 8,
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    multiword_cla_seq_if.slave    bus
);
    localparam int N  = W * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;
    logic            accept;
    logic            last;

    logic [N-1:0]    a_sh;
    logic [N-1:0]    b_sh;
    logic            carry;
    logic [IW-1:0]   idx;
    logic [N-1:0]    sum_r;
    logic            cout_r;
    logic            ovf_r;

    logic [W-1:0]    g;
    logic [W-1:0]    p;
    logic [W:0]      c;
    logic [W-1:0]    s;

    // Each carry is a flat sum of products of g/p and the carry register,
    // so no carry depends on the previous one.
    always_comb begin : cla_slice
        logic acc;
        logic term;
        g = a_sh[W-1:0] & b_sh[W-1:0];
        p = a_sh[W-1:0] ^ b_sh[W-1:0];
        c = '0;
        c[0] = carry;
        acc  = 1'b0;
        term = 1'b0;
        for (int i = 0; i < W; i++) begin
            acc = carry;
            for (int j = 0; j <= i; j++) begin
                acc = acc & p[j];
            end
            for (int j = 0; j <= i; j++) begin
                term = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    term = term & p[k];
                end
                acc = acc | term;
            end
            c[i+1] = acc;
        end
        s = p ^ c[W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        last       = (idx == IW'(WORDS - 1));
        bus.busy   = 1'b0;
        bus.done   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end
            end
            RUN: begin
                bus.busy = 1'b1;
                if (last) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                bus.done = 1'b1;
                if (bus.start) begin
                    accept     = 1'b1;
                    next_state = RUN;
                end else begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Subtraction is A + ~B + 1, so B is inverted once at capture time.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            carry  <= 1'b0;
            idx    <= '0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else if (accept) begin
            a_sh  <= bus.a_in;
            b_sh  <= bus.sub ? ~bus.b_in : bus.b_in;
            carry <= bus.sub ? 1'b1 : bus.cin;
            idx   <= '0;
            sum_r <= '0;
        end else if (state == RUN) begin
            sum_r[idx*W +: W] <= s;
            carry             <= c[W];
            a_sh              <= a_sh >> W;
            b_sh              <= b_sh >> W;
            if (last) begin
                idx    <= '0;
                cout_r <= c[W];
                ovf_r  <= c[W] ^ c[W-1];
            end else begin
                idx <= idx + IW'(1);
            end
        end
    end

    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
    assign bus.ovf  = ovf_r;
endmodule

// File: tb/tb_multiword_cla_seq.sv
// Scoreboard bench for multiword_cla_seq: the driver queues hand-computed
// results, a negedge monitor checks them whenever done pulses.
module tb_multiword_cla_seq;
    localparam int W     = 8;
    localparam int WORDS = 4;
    localparam int N     = W * WORDS;

    typedef struct {
        logic [N-1:0] sum;
        logic         cout;
        logic         ovf;
        string        name;
    } exp_t;

    logic clk;
    logic rst;
    int   compared;
    int   mismatched;
    exp_t expq[$];

    multiword_cla_seq_if #(.W(W), .WORDS(WORDS)) bus ();

    multiword_cla_seq #(.W(W), .WORDS(WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: any done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && bus.done === 1'b1) begin
            if (expq.size() == 0) begin
                checkOutput("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = expq.pop_front();
                checkOutput({e.name, "_sum"},  64'(bus.sum),  64'(e.sum));
                checkOutput({e.name, "_cout"}, 64'(bus.cout), 64'(e.cout));
                checkOutput({e.name, "_ovf"},  64'(bus.ovf),  64'(e.ovf));
            end
        end
    end

    // Called at a negedge; returns just after the accepting posedge.
    task automatic applyStimulus(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                                 input logic s, input logic ci, input logic [N-1:0] esum,
                                 input logic ecout, input logic eovf, input logic hold);
        exp_t e;
        e.sum  = esum;
        e.cout = ecout;
        e.ovf  = eovf;
        e.name = name;
        expq.push_back(e);
        bus.a_in  = a;
        bus.b_in  = b;
        bus.sub   = s;
        bus.cin   = ci;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) bus.start = 1'b0;
    endtask

    task automatic waitDone(input string name, output int lat, output int busyCnt);
        lat     = 0;
        busyCnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            lat++;
            if (bus.busy === 1'b1) busyCnt++;
            if (bus.done === 1'b1) return;
        end
        checkOutput({name, "_timeout"}, 64'd1, 64'd0);
    endtask

    initial begin
        int lat;
        int busyCnt;
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.sub    = 1'b0;
        bus.a_in   = '0;
        bus.b_in   = '0;
        bus.cin    = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checkOutput("reset_busy", 64'(bus.busy), 64'd0);
        checkOutput("reset_done", 64'(bus.done), 64'd0);
        checkOutput("reset_sum",  64'(bus.sum),  64'd0);
        checkOutput("reset_cout", 64'(bus.cout), 64'd0);
        checkOutput("reset_ovf",  64'(bus.ovf),  64'd0);

        applyStimulus("add_ff_1", 32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0);
        waitDone("add_ff_1", lat, busyCnt);
        checkOutput("latency", 64'(lat), 64'd5);
        checkOutput("busy_cycles", 64'(busyCnt), 64'd4);
        @(negedge clk);

        applyStimulus("carry_chain", 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b0);
        waitDone("carry_chain", lat, busyCnt);
        @(negedge clk);

        applyStimulus("sub_borrow", 32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        waitDone("sub_borrow", lat, busyCnt);
        @(negedge clk);

        applyStimulus("sub_ovf", 32'h80000000, 32'h00000001, 1'b1, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
        waitDone("sub_ovf", lat, busyCnt);
        @(negedge clk);

        applyStimulus("add_ovf", 32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
        waitDone("add_ovf", lat, busyCnt);
        @(negedge clk);

        // A start pulse and operand changes mid-run must not disturb the result.
        applyStimulus("ignored_start", 32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0, 1'b0);
        bus.a_in = 32'hDEADBEEF;
        bus.b_in = 32'hFFFFFFFF;
        bus.sub  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        waitDone("ignored_start", lat, busyCnt);
        @(negedge clk);

        // Start held high: a new operation is accepted at each DONE edge.
        applyStimulus("b2b_0", 32'hFFFF0000, 32'h00010000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1);
        waitDone("b2b_0", lat, busyCnt);
        applyStimulus("b2b_1", 32'h40000000, 32'h40000000, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b1);
        waitDone("b2b_1", lat, busyCnt);
        checkOutput("b2b_period_1", 64'(lat), 64'd5);
        applyStimulus("b2b_2", 32'h00000010, 32'h00000010, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b0);
        waitDone("b2b_2", lat, busyCnt);
        checkOutput("b2b_period_2", 64'(lat), 64'd5);
        @(negedge clk);

        // Reset during the second RUN cycle aborts silently.
        bus.a_in  = 32'h01020304;
        bus.b_in  = 32'h05060708;
        bus.sub   = 1'b0;
        bus.cin   = 1'b0;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_busy", 64'(bus.busy), 64'd0);
        checkOutput("abort_done", 64'(bus.done), 64'd0);
        checkOutput("abort_sum",  64'(bus.sum),  64'd0);
        checkOutput("abort_cout", 64'(bus.cout), 64'd0);
        checkOutput("abort_ovf",  64'(bus.ovf),  64'd0);
        repeat (8) @(negedge clk);

        applyStimulus("after_abort", 32'h01020304, 32'h05060708, 1'b0, 1'b1, 32'h06080A0D, 1'b0, 1'b0, 1'b0);
        waitDone("after_abort", lat, busyCnt);
        repeat (3) @(negedge clk);

        checkOutput("queue_empty", 64'(expq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
